md5_padder: RTL

MD5_PADDER -- requirements
Module: md5_padder

---
 rtl/md5_padder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/md5_padder.sv
// MD5 message padder: collects message bytes into a 512-bit block, appends the
// 0x80 marker and the 64-bit little-endian bit length, and hands each block to
// an MD5 core with a start/resume pulse, waiting on the core's done flag.
`timescale 1ns/1ps
module md5_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [0:511] blk_data,
    output logic         blk_start,
    output logic         blk_resume,
    input  logic         core_done,
    output logic         msg_done
);

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD,
        S_EXTRA,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       state_reg;
    state_t       state_next;

    logic [0:511] blk_reg;       // block buffer, byte k at bits [8k +: 8]
    logic [5:0]   idx_reg;       // next byte slot in the current block
    logic [60:0]  len_reg;       // message length in bytes, wraps mod 2^61
    logic         pend_pad_reg;  // message ended exactly on a block boundary
    logic         extra_reg;     // 0x80 landed past byte 55, length needs its own block
    logic         final_reg;     // buffered block is the last block of the message
    logic         first_reg;     // next block opens a new message (blk_start)

    logic         xfer;
    logic [63:0]  bit_len;
    logic [7:0]   len_byte [8];

    assign blk_data = blk_reg;
    assign in_ready = (state_reg == S_FILL) && !rst;
    assign xfer     = in_valid && in_ready;
    assign bit_len  = {len_reg, 3'b000};

    // Split the bit length into little-endian bytes for slots 56..63.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_len_byte
            assign len_byte[gi] = bit_len[8*gi +: 8];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and pulse outputs, decoded from the current state only.
    always_comb begin
        state_next = state_reg;
        blk_start  = 1'b0;
        blk_resume = 1'b0;
        msg_done   = 1'b0;
        case (state_reg)
            S_FILL: begin
                if (xfer) begin
                    if (in_last) begin
                        state_next = S_PAD;
                    end else if (idx_reg == 6'd63) begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_PAD:   state_next = S_ISSUE;
            S_EXTRA: state_next = S_ISSUE;
            S_ISSUE: begin
                blk_start  = first_reg;
                blk_resume = !first_reg;
                state_next = S_ARM;
            end
            // core_done may still be high from the previous block here.
            S_ARM:   state_next = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    if (final_reg) begin
                        state_next = S_DONE;
                    end else if (extra_reg || pend_pad_reg) begin
                        state_next = S_EXTRA;
                    end else begin
                        state_next = S_FILL;
                    end
                end
            end
            S_DONE: begin
                msg_done   = 1'b1;
                state_next = S_FILL;
            end
            default: state_next = S_FILL;
        endcase
    end

    // Block buffer, byte index, length counter and message flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_reg      <= '0;
            idx_reg      <= '0;
            len_reg      <= '0;
            pend_pad_reg <= 1'b0;
            extra_reg    <= 1'b0;
            final_reg    <= 1'b0;
            first_reg    <= 1'b1;
        end else begin
            case (state_reg)
                S_FILL: begin
                    if (xfer) begin
                        blk_reg[{idx_reg, 3'b000} +: 8] <= in_data;
                        idx_reg <= idx_reg + 6'd1;
                        len_reg <= len_reg + 61'd1;
                        if (in_last && (idx_reg == 6'd63)) begin
                            pend_pad_reg <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    // A full final block goes out untouched; padding follows in EXTRA.
                    if (!pend_pad_reg) begin
                        blk_reg[{idx_reg, 3'b000} +: 8] <= 8'h80;
                        if (idx_reg <= 6'd55) begin
                            for (int k = 0; k < 8; k++) begin
                                blk_reg[(56+k)*8 +: 8] <= len_byte[k];
                            end
                            final_reg <= 1'b1;
                        end else begin
                            extra_reg <= 1'b1;
                        end
                    end
                end
                S_EXTRA: begin
                    blk_reg <= '0;
                    if (pend_pad_reg) begin
                        blk_reg[0 +: 8] <= 8'h80;
                    end
                    for (int k = 0; k < 8; k++) begin
                        blk_reg[(56+k)*8 +: 8] <= len_byte[k];
                    end
                    final_reg    <= 1'b1;
                    pend_pad_reg <= 1'b0;
                    extra_reg    <= 1'b0;
                end
                S_ISSUE: begin
                    first_reg <= 1'b0;
                end
                S_WAIT: begin
                    // Plain data block finished: start the next one from a clean buffer.
                    if (core_done && !final_reg && !extra_reg && !pend_pad_reg) begin
                        blk_reg <= '0;
                        idx_reg <= '0;
                    end
                end
                S_DONE: begin
                    blk_reg      <= '0;
                    idx_reg      <= '0;
                    len_reg      <= '0;
                    pend_pad_reg <= 1'b0;
                    extra_reg    <= 1'b0;
                    final_reg    <= 1'b0;
                    first_reg    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
